// File: rtl/nios_debug_jtag_pkg.sv
// Shared definitions for the host-side virtual-JTAG debug shifter.
//   - state_t           : shifter FSM states, in sequence order
//   - IR_* encodings    : 2-bit virtual IR values of the Nios II debug slave
//   - DEFAULT_DR_WIDTH  : debug slave shift-register length
//   - in_slot()         : true for states that run TCK slots
package nios_debug_jtag_pkg;

    localparam int unsigned DEFAULT_DR_WIDTH = 38;
    localparam int unsigned DEFAULT_IR_WIDTH = 2;

    localparam logic [1:0] IR_OCIMEM = 2'b00;
    localparam logic [1:0] IR_TRACE  = 2'b01;
    localparam logic [1:0] IR_BREAK  = 2'b10;
    localparam logic [1:0] IR_ENABLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RESP = 3'd5
    } state_t;

    function automatic logic in_slot(input state_t s);
        return (s == UIR) || (s == CDR) || (s == SDR) || (s == UDR);
    endfunction

endpackage

// File: rtl/nios_debug_jtag_host_shifter_tck_gen.sv
// TCK slot generator. While enable is high, counts 2*TCK_DIV clk per slot:
// low half first, then high half.
//   clk, reset_n  : system clock, async active-low reset
//   enable        : FSM is in a slot-running state
//   tck           : registered TCK, low whenever enable is low
//   slot_start    : first clk of a slot (start of the low half)
//   sample_pulse  : last clk of the high half; also the slot-end strobe
module nios_debug_jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tck,
    output logic slot_start,
    output logic sample_pulse
);

    localparam int unsigned CW = $clog2(2 * TCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          tck_q;

    always_comb begin
        cnt_next = '0;
        if (enable && (cnt != LAST)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // TCK is registered from the next count so it lines up with the count
    // it describes rather than trailing it by a clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            tck_q <= enable && (cnt_next >= HALF);
        end
    end

    assign tck          = tck_q;
    assign slot_start   = enable && (cnt == '0);
    assign sample_pulse = enable && (cnt == LAST);

endmodule

// File: rtl/nios_debug_jtag_host_shifter.sv
// Host-side initiator for the 2-bit-IR virtual-JTAG debug channel.
// Accepts an (IR, DR) command, runs UIR, CDR, DR_WIDTH-bit SDR, UDR on the
// vji_* strobes with a generated TCK, and returns captured TDO bits plus the
// target's ir_out sampled during UIR.
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr      : command handshake
//   rsp_valid/rsp_ready/rsp_dr/rsp_ir_out  : result handshake
//   vji_tck/vji_tdi/vji_tdo                : serial path to target
//   vji_ir_in/vji_ir_out                   : virtual IR to/from target
//   vji_uir/cdr/sdr/udr/rti                : virtual state strobes
module nios_debug_jtag_host_shifter
    import nios_debug_jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int unsigned IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned BCW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DR_WIDTH - 1);

    state_t              state;
    logic [DR_WIDTH-1:0] sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_out_q;
    logic [BCW-1:0]      bit_cnt;
    logic                tdi_q;
    logic                armed;
    logic                slot_start;
    logic                sample_pulse;

    nios_debug_jtag_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (in_slot(state)),
        .tck         (vji_tck),
        .slot_start  (slot_start),
        .sample_pulse(sample_pulse)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sr       <= '0;
            ir_q     <= '0;
            ir_out_q <= '0;
            bit_cnt  <= '0;
            tdi_q    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        ir_q  <= cmd_ir;
                        sr    <= cmd_dr;
                        state <= UIR;
                    end
                end
                UIR: begin
                    if (sample_pulse) begin
                        ir_out_q <= vji_ir_out;
                        state    <= CDR;
                    end
                end
                CDR: begin
                    if (sample_pulse) begin
                        // Preloaded to all-ones so the first SDR slot_start
                        // wraps it to bit 0.
                        bit_cnt <= '1;
                        tdi_q   <= sr[0];
                        state   <= SDR;
                    end
                end
                SDR: begin
                    if (slot_start) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (sample_pulse) begin
                        sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            tdi_q <= 1'b0;
                            state <= UDR;
                        end else begin
                            // sr[1] becomes sr[0] on this same edge.
                            tdi_q <= sr[1];
                        end
                    end
                end
                UDR: begin
                    if (sample_pulse) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // armed keeps cmd_ready/vji_rti low during reset and releases them on
    // the first clk afterwards.
    assign cmd_ready  = armed && (state == IDLE);
    assign vji_rti    = armed && (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_dr     = sr;
    assign rsp_ir_out = ir_out_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_q;
    assign vji_uir    = (state == UIR);
    assign vji_cdr    = (state == CDR);
    assign vji_sdr    = (state == SDR);
    assign vji_udr    = (state == UDR);

endmodule

// File: tb/tb_nios_debug_jtag_host_shifter.sv
module tb_nios_debug_jtag_host_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0: default TCK_DIV=4, 38-bit target model on the serial path
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_dr, rsp_dr;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios_debug_jtag_host_shifter #(
        .DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    // DUT1: TCK_DIV=1, tdo wired straight back to tdi
    logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
    logic [1:0]  cmd_ir1, rsp_ir_out1, vji_ir_in1, vji_ir_out1;
    logic [37:0] cmd_dr1, rsp_dr1;
    logic        vji_tck1, vji_tdi1, vji_tdo1;
    logic        vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;
    assign vji_tdo1 = vji_tdi1;

    nios_debug_jtag_host_shifter #(
        .DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1),
        .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
        .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out1),
        .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1), .vji_udr(vji_udr1),
        .vji_rti(vji_rti1)
    );

    wire [50:0] outs0 = {cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vji_tck, vji_tdi,
                         vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
    wire [50:0] outs1 = {cmd_ready1, rsp_valid1, rsp_dr1, rsp_ir_out1, vji_tck1, vji_tdi1,
                         vji_ir_in1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Target model: captures tdi/sdr on rising TCK, shifts on falling TCK.
    logic [37:0] tgt_sr;
    logic        tgt_tdi_q, tgt_en_q;
    logic [1:0]  tgt_ir;
    always @(posedge vji_tck or negedge reset_n) begin
        if (!reset_n) begin
            tgt_tdi_q <= 1'b0;
            tgt_en_q  <= 1'b0;
        end else begin
            tgt_tdi_q <= vji_tdi;
            tgt_en_q  <= vji_sdr;
        end
    end
    always @(negedge vji_tck or negedge reset_n) begin
        if (!reset_n) tgt_sr <= '0;
        else if (tgt_en_q) tgt_sr <= {tgt_tdi_q, tgt_sr[37:1]};
    end
    assign vji_tdo    = tgt_sr[0];
    assign vji_ir_out = tgt_ir;

    // Scoreboard for DUT0
    typedef struct packed {
        logic [37:0] dr;
        logic [1:0]  ir;
    } exp_t;
    exp_t exp_q[$];
    logic [1:0]  exp_ir_in = '0;
    logic        prev_rv = 1'b0;
    logic [3:0]  s0_prev = '0;
    int unsigned acc_cyc = 0;
    int          uir_rises = 0;
    int          udr_rises = 0;

    always @(negedge clk) begin
        logic [3:0] s0;
        exp_t e;
        s0 = {vji_uir, vji_cdr, vji_sdr, vji_udr};
        if (reset_n) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rsp_valid && !prev_rv) check("latency", 64'(cyc - acc_cyc), 64'd329);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", rsp_dr);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
                    check("rsp_ir_out", 64'(rsp_ir_out), 64'(e.ir));
                end
            end
            if (s0 != 4'b0 && s0 != s0_prev) check("ir_in_hold", 64'(vji_ir_in), 64'(exp_ir_in));
            if (vji_uir && !s0_prev[3]) uir_rises++;
            if (vji_udr && !s0_prev[0]) udr_rises++;
        end
        prev_rv = rsp_valid;
        s0_prev = s0;
    end

    // Strobe sequencing and response monitor for DUT1
    int          exp_len[4] = '{2, 2, 76, 2};
    logic [3:0]  s1_prev = '0;
    int          run_len = 0;
    int          phase = 0;
    logic        prev_rv1 = 1'b0;
    logic        rsp1_seen = 1'b0;
    int unsigned acc1 = 0;
    logic [37:0] exp1_dr = '0;

    always @(negedge clk) begin
        logic [3:0] s1;
        s1 = {vji_uir1, vji_cdr1, vji_sdr1, vji_udr1};
        if (reset_n) begin
            if (cmd_valid1 && cmd_ready1) acc1 = cyc;
            if (s1 != 4'b0) begin
                check("strobe_onehot", 64'($countones(s1)), 64'd1);
                check("rti_low", 64'(vji_rti1), 64'd0);
            end
            if (s1_prev != 4'b0 && s1 != s1_prev) begin
                if (phase < 4) begin
                    check("strobe_order", 64'(s1_prev), 64'(4'b1000 >> phase));
                    check("strobe_len", 64'(run_len), 64'(exp_len[phase]));
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL extra_strobe actual=%0h required=none", s1_prev);
                end
                phase++;
            end
            if (s1 != 4'b0) run_len = (s1 == s1_prev) ? run_len + 1 : 1;
            if (rsp_valid1 && !prev_rv1) begin
                check("latency_div1", 64'(cyc - acc1), 64'd83);
                check("rsp_dr_div1", 64'(rsp_dr1), 64'(exp1_dr));
                check("rsp_ir_div1", 64'(rsp_ir_out1), 64'd0);
                rsp1_seen = 1'b1;
            end
        end
        prev_rv1 = rsp_valid1;
        s1_prev  = s1;
    end

    task automatic send0(input logic [37:0] dr, input logic [1:0] ir,
                         input logic [1:0] tir, input logic [37:0] exp_dr);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=cmd_ready_0 required=1");
            return;
        end
        e.dr = exp_dr;
        e.ir = tir;
        exp_q.push_back(e);
        tgt_ir    = tir;
        exp_ir_in = ir;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(exp_q.size() == 0 && cmd_ready), 64'd1);
    endtask

    initial begin
        logic [37:0] hold;
        int n;
        int uir_before, udr_before;
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
        cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_dr1 = '0; rsp_ready1 = 1'b1;
        vji_ir_out1 = 2'b00;
        tgt_ir = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs0), 64'd0);
        check("reset_outputs_div1", 64'(outs1), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        #1 check("ready_before_first_clk", 64'({cmd_ready, vji_rti}), 64'd0);
        @(posedge clk); #1;
        check("ready_after_reset", 64'({cmd_ready, vji_rti}), 64'b11);

        // Strobe sequencing at TCK_DIV=1; direct loopback rotates DR back to itself
        exp1_dr    = 38'h15_5555_5555;
        cmd_dr1    = 38'h15_5555_5555;
        cmd_ir1    = 2'b11;
        cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        n = 0;
        while (!rsp1_seen && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_seen_div1", 64'(rsp1_seen), 64'd1);
        check("strobe_phases", 64'(phase), 64'd4);

        // Loopback: first response is the target's reset contents
        send0(38'h2_A5A5_A5A5, 2'b00, 2'b11, 38'h0);
        wait_drain("drain_a");

        // Backpressure on the second command
        rsp_ready = 1'b0;
        send0(38'h0, 2'b00, 2'b10, 38'h2_A5A5_A5A5);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        hold = rsp_dr;
        check("bp_captured", 64'(hold), 64'(38'h2_A5A5_A5A5));
        uir_before = uir_rises;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) begin
                cmd_dr = 38'h3F_FFFF_FFFF;
                cmd_valid = 1'b1;
            end
            if (i == 11) cmd_valid = 1'b0;
            check("bp_valid_stable", 64'(rsp_valid), 64'd1);
            check("bp_dr_stable", 64'(rsp_dr), 64'(hold));
            check("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
            check("bp_tck_low", 64'(vji_tck), 64'd0);
        end
        check("bp_no_new_uir", 64'(uir_rises), 64'(uir_before));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain("drain_b");

        // IR path
        send0(38'h3F_FFFF_0000, 2'b10, 2'b01, 38'h0);
        wait_drain("drain_ir");

        // Reset during SDR bit 17 aborts the access
        send0(38'h12_3456_789A, 2'b01, 2'b00, 38'h0);
        n = 0;
        while (!vji_sdr && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_sdr", 64'(vji_sdr), 64'd1);
        repeat (17 * 8 + 3) @(posedge clk);
        #1;
        check("still_in_sdr", 64'(vji_sdr), 64'd1);
        udr_before = udr_rises;
        reset_n = 1'b0;
        #1 check("abort_outputs", 64'(outs0), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        check("abort_no_udr", 64'(udr_rises), 64'(udr_before));
        @(posedge clk); #1;
        check("ready_after_abort", 64'(cmd_ready), 64'd1);

        // Fresh commands: target model was reset with the DUT
        send0(38'h0F_0F0F_0F0F, 2'b11, 2'b10, 38'h0);
        wait_drain("drain_d");
        send0(38'h0, 2'b00, 2'b00, 38'h0F_0F0F_0F0F);
        wait_drain("drain_e");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_debug_jtag_host_shifter.md
Name: nios_debug_jtag_host_shifter

Overview:
Host-side initiator for the 2-bit-IR virtual-JTAG debug channel of the on-chip Nios II debug slave. It takes an (IR, 38-bit DR) command from a local controller and drives the virtual-JTAG strobes and TCK/TDI. The sequence is UIR, CDR, DR_WIDTH-bit SDR shift, then UDR. It returns the 38 TDO bits captured during the shift, plus the target's ir_out sampled at UIR. Used in simulation and in the self-test fabric in place of the hard sld hub.

Parameters:
DR_WIDTH, 38, shift-register length (matches debug slave sr width)
IR_WIDTH, 2, virtual IR width
TCK_DIV, 4, clk cycles per TCK half-period (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  shifter can accept command
cmd_ir  in  IR_WIDTH  IR value for this access
cmd_dr  in  DR_WIDTH  data shifted into target, LSB first
rsp_valid  out  1  captured result available
rsp_ready  in  1  consumer takes result
rsp_dr  out  DR_WIDTH  TDO bits captured; first-shifted bit in [0]
rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR
vji_tck  out  1  generated TCK
vji_tdi  out  1  serial data to target
vji_tdo  in  1  serial data from target
vji_ir_in  out  IR_WIDTH  IR presented to target
vji_ir_out  in  IR_WIDTH  target IR status
vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes
vji_rti  out  1  run-test-idle indicator

Behaviour:
- Reset state:
  - All outputs 0, including vji_tck, strobes, rsp_valid, cmd_ready and vji_rti.
  - FSM = IDLE.
  - cmd_ready and vji_rti rise on the first clk after reset_n deasserts.
- Reset asserted mid-operation aborts immediately. No UDR is issued and any partial result is discarded.
- TCK period ("slot") = 2*TCK_DIV clk:
  - The low half comes first, then the high half.
  - vji_tck is registered and is low whenever the FSM is IDLE or RESP.
- FSM states: IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1 and vji_rti=1.
  - On cmd_valid&&cmd_ready, latch cmd_ir into vji_ir_in and cmd_dr into the shift register, then go to UIR the next clk.
  - cmd_valid while not ready is ignored.
- UIR: one slot, vji_uir=1. rsp_ir_out is sampled in the last clk of the high half.
- CDR: one slot, vji_cdr=1.
- SDR: DR_WIDTH slots, vji_sdr=1 throughout.
  - vji_tdi = sr[0], updated at the start of each low half.
  - vji_tdo is sampled in the last clk of each high half.
  - Shift: sr <= {tdo, sr[DR_WIDTH-1:1]}.
  - Bit counter runs 0..DR_WIDTH-1; the state exits after the slot with count DR_WIDTH-1.
- UDR: one slot, vji_udr=1. vji_ir_in is held stable from UIR through UDR.
- RESP:
  - rsp_valid=1 with rsp_dr = sr and rsp_ir_out stable.
  - The state is held until rsp_ready. On rsp_valid&&rsp_ready go to IDLE and cmd_ready=1 on the next clk.
- Only one strobe is high at a time. vji_rti=0 outside IDLE.
- Latency:
  - Measured from the clk where the command is accepted (cycle 0).
  - rsp_valid rises at cycle 1 + (DR_WIDTH+3)*2*TCK_DIV; defaults give 329.
  - At most one command is in flight; there is no buffering.
- rsp_ready asserted while rsp_valid=0 has no effect.
- TCK_DIV=1 must work: each half-period is one clk, and sampling and update land on the same half boundaries.

Decomposition:
- Shared package nios_debug_jtag_pkg holds:
  - State enum (IDLE, UIR, CDR, SDR, UDR, RESP).
  - IR encodings: IR_OCIMEM=2'b00, IR_TRACE=2'b01, IR_BREAK=2'b10, IR_ENABLE=2'b11.
  - Default DR_WIDTH.
- One natural sub-module, nios_debug_jtag_tck_gen: a TCK_DIV divider that outputs tck, slot_start and sample_pulse (the last clk of the high half). The FSM advances on the slot-end strobe.

Test Plan:
- Loopback, tdo wired to tdi through a 38-bit target model:
  - Stimulus: cmd_ir=2'b00, cmd_dr=38'h2_A5A5_A5A5, then a second command with cmd_dr=38'h0.
  - Required: the first rsp_dr equals the model's reset contents (0). The second rsp_dr = 38'h2_A5A5_A5A5. rsp_valid rises exactly 329 clk after each accept.
- Strobe sequencing, TCK_DIV=1:
  - Required: vji_uir high for exactly 2 clk, then vji_cdr for 2, vji_sdr for 76, vji_udr for 2.
  - No two strobes overlap. vji_rti=0 throughout.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 50 clk after rsp_valid.
  - Required: rsp_dr and rsp_valid remain stable. cmd_ready=0. A cmd_valid pulse in this window is ignored, with no new UIR.
- IR path:
  - Stimulus: cmd_ir=2'b10 with the target driving vji_ir_out=2'b01.
  - Required: vji_ir_in=2'b10 held from UIR through UDR, and rsp_ir_out=2'b01.
- Reset mid-shift:
  - Stimulus: assert reset_n=0 at SDR bit 17.
  - Required: all outputs 0 in the same cycle with no UDR pulse. After release, cmd_ready=1 and a fresh command completes normally.
